// File: rtl/operand_fetch_if.sv
// Bundle of IF/ID, register-file, bypass and ID/EX signals around the operand-fetch stage.
// The slave modport is the stage itself; the master modport is whoever surrounds it.
interface operand_fetch_if #(
   parameter int unsigned XLEN = 32
);
   logic            id_valid;
   logic            id_ready;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;

   logic [4:0]      rf_raddr1;
   logic [4:0]      rf_raddr2;
   logic [XLEN-1:0] rf_rdata1;
   logic [XLEN-1:0] rf_rdata2;

   logic            fx_valid;
   logic [4:0]      fx_rd;
   logic [XLEN-1:0] fx_data;
   logic            fx_rdy;

   logic            fm_valid;
   logic [4:0]      fm_rd;
   logic [XLEN-1:0] fm_data;
   logic            fm_rdy;

   logic            wb_wen;
   logic [4:0]      wb_waddr;
   logic [XLEN-1:0] wb_wdata;

   logic            ex_valid;
   logic            ex_ready;
   logic [XLEN-1:0] ex_pc;
   logic [31:0]     ex_instr;
   logic [XLEN-1:0] ex_rs1_val;
   logic [XLEN-1:0] ex_rs2_val;
   logic [XLEN-1:0] ex_imm;

   modport slave (
      input  id_valid, id_instr, id_pc, rf_rdata1, rf_rdata2,
             fx_valid, fx_rd, fx_data, fx_rdy,
             fm_valid, fm_rd, fm_data, fm_rdy,
             wb_wen, wb_waddr, wb_wdata, ex_ready,
      output id_ready, rf_raddr1, rf_raddr2,
             ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm
   );

   modport master (
      output id_valid, id_instr, id_pc, rf_rdata1, rf_rdata2,
             fx_valid, fx_rd, fx_data, fx_rdy,
             fm_valid, fm_rd, fm_data, fm_rdy,
             wb_wen, wb_waddr, wb_wdata, ex_ready,
      input  id_ready, rf_raddr1, rf_raddr2,
             ex_valid, ex_pc, ex_instr, ex_rs1_val, ex_rs2_val, ex_imm
   );
endinterface

// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: bypasses EX/MEM/WB results into rs1/rs2, builds the
// immediate, stalls on unready producers and registers everything into ID/EX.
module operand_fetch #(
   parameter int unsigned XLEN = 32
) (
   input  logic                   clk,
   input  logic                   srst_n,
   input  logic                   flush,
   operand_fetch_if.slave         bus,
   output logic [31:0]            stall_cycles
);
   localparam int unsigned ILEN = 32;
   localparam int unsigned RAW  = 5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IALU   = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   logic [6:0]                opcode;
   logic [1:0]                used;
   logic [1:0][RAW-1:0]       rs;
   logic [1:0][XLEN-1:0]      rfd;
   logic [1:0][XLEN-1:0]      opv;
   logic [1:0]                src_hz;
   logic                      hazard;
   logic                      load_ok;
   logic                      accept;
   logic [XLEN-1:0]           imm;

   logic                      ex_valid_q,   ex_valid_d;
   logic [XLEN-1:0]           ex_pc_q,      ex_pc_d;
   logic [ILEN-1:0]           ex_instr_q,   ex_instr_d;
   logic [XLEN-1:0]           ex_rs1_q,     ex_rs1_d;
   logic [XLEN-1:0]           ex_rs2_q,     ex_rs2_d;
   logic [XLEN-1:0]           ex_imm_q,     ex_imm_d;
   logic [31:0]               stall_q,      stall_d;

   assign opcode        = bus.id_instr[6:0];
   assign rs[0]         = bus.id_instr[19:15];
   assign rs[1]         = bus.id_instr[24:20];
   assign rfd[0]        = bus.rf_rdata1;
   assign rfd[1]        = bus.rf_rdata2;
   assign bus.rf_raddr1 = rs[0];
   assign bus.rf_raddr2 = rs[1];

   // Which source fields the opcode actually reads
   always_comb begin
      used = 2'b00;
      unique case (opcode)
         OP_R, OP_STORE, OP_BRANCH: used = 2'b11;
         OP_IALU, OP_LOAD, OP_JALR: used = 2'b01;
         default:                   used = 2'b00;
      endcase
   end

   // First-match bypass; x0 short-circuits so rd==0 producers never match
   always_comb begin
      opv    = rfd;
      src_hz = 2'b00;
      for (int i = 0; i < 2; i++) begin
         if (rs[i] == '0) begin
            opv[i] = '0;
         end else if (bus.fx_valid && bus.fx_rd == rs[i]) begin
            opv[i]    = bus.fx_data;
            src_hz[i] = !bus.fx_rdy;
         end else if (bus.fm_valid && bus.fm_rd == rs[i]) begin
            opv[i]    = bus.fm_data;
            src_hz[i] = !bus.fm_rdy;
         end else if (bus.wb_wen && bus.wb_waddr == rs[i]) begin
            opv[i] = bus.wb_wdata;
         end
      end
   end

   assign hazard       = |(used & src_hz);
   assign load_ok      = !ex_valid_q || bus.ex_ready;
   assign accept       = bus.id_valid && !hazard && load_ok && !flush;
   assign bus.id_ready = flush || (!hazard && load_ok);

   always_comb begin
      imm = '0;
      unique case (opcode)
         OP_IALU, OP_LOAD, OP_JALR:
            imm = XLEN'($signed(bus.id_instr[31:20]));
         OP_STORE:
            imm = XLEN'($signed({bus.id_instr[31:25], bus.id_instr[11:7]}));
         OP_BRANCH:
            imm = XLEN'($signed({bus.id_instr[31], bus.id_instr[7], bus.id_instr[30:25],
                                 bus.id_instr[11:8], 1'b0}));
         OP_LUI, OP_AUIPC:
            imm = XLEN'($signed({bus.id_instr[31:12], 12'b0}));
         OP_JAL:
            imm = XLEN'($signed({bus.id_instr[31], bus.id_instr[19:12], bus.id_instr[20],
                                 bus.id_instr[30:21], 1'b0}));
         default:
            imm = '0;
      endcase
   end

   // Next-state for the ID/EX register and stall counter
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_pc_d    = ex_pc_q;
      ex_instr_d = ex_instr_q;
      ex_rs1_d   = ex_rs1_q;
      ex_rs2_d   = ex_rs2_q;
      ex_imm_d   = ex_imm_q;
      stall_d    = stall_q;

      if (flush) begin
         ex_valid_d = 1'b0;
      end else if (accept) begin
         ex_valid_d = 1'b1;
         ex_pc_d    = bus.id_pc;
         ex_instr_d = bus.id_instr;
         ex_rs1_d   = opv[0];
         ex_rs2_d   = opv[1];
         ex_imm_d   = imm;
      end else if (load_ok) begin
         ex_valid_d = 1'b0;
      end

      if (bus.id_valid && hazard && !flush && stall_q != '1) begin
         stall_d = stall_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!srst_n) begin
         ex_valid_q <= 1'b0;
         ex_pc_q    <= '0;
         ex_instr_q <= '0;
         ex_rs1_q   <= '0;
         ex_rs2_q   <= '0;
         ex_imm_q   <= '0;
         stall_q    <= '0;
      end else begin
         ex_valid_q <= ex_valid_d;
         ex_pc_q    <= ex_pc_d;
         ex_instr_q <= ex_instr_d;
         ex_rs1_q   <= ex_rs1_d;
         ex_rs2_q   <= ex_rs2_d;
         ex_imm_q   <= ex_imm_d;
         stall_q    <= stall_d;
      end
   end

   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_pc      = ex_pc_q;
   assign bus.ex_instr   = ex_instr_q;
   assign bus.ex_rs1_val = ex_rs1_q;
   assign bus.ex_rs2_val = ex_rs2_q;
   assign bus.ex_imm     = ex_imm_q;
   assign stall_cycles   = stall_q;
endmodule
